// File: rtl/alu32_seq_pkg.sv
// Shared types and 74181 select codes for the sequenced 64-bit ALU controller.
package alu32_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] SEL_ADD = 4'b1001;  // M=0: A plus B
  localparam logic [3:0] SEL_SUB = 4'b0110;  // M=0: A minus B minus 1 (plus carry)
  localparam logic [3:0] SEL_XOR = 4'b0110;  // M=1: A xor B

endpackage

// File: rtl/alu32.sv
// 32-bit 74181-style ALU: active-high data, active-low carry in/out, combinational.
module alu32 #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mode,
  input  logic [3:0]        sel,
  input  logic              cin_n,
  output logic [DATA_W-1:0] f,
  output logic              cout_n
);

  logic [DATA_W-1:0] t_or;
  logic [DATA_W-1:0] t_and;
  logic [DATA_W:0]   sum;

  // Arithmetic is t_or + t_and + carry; logic mode is the xnor of the same terms inverted.
  always_comb begin
    t_or   = a | (b & {DATA_W{sel[0]}}) | (~b & {DATA_W{sel[1]}});
    t_and  = (a & ~b & {DATA_W{sel[2]}}) | (a & b & {DATA_W{sel[3]}});
    sum    = {1'b0, t_or} + {1'b0, t_and} + {{DATA_W{1'b0}}, ~cin_n};
    f      = sum[DATA_W-1:0];
    cout_n = ~sum[DATA_W];
    if (mode) begin
      f      = ~(t_or ^ t_and);
      cout_n = 1'b1;
    end
  end

endmodule

// File: rtl/alu32_seq_ctrl.sv
// Runs 64-bit (two-pass) or 32-bit (one-pass) ops through a single alu32, valid/ready on both sides.
module alu32_seq_ctrl
  import alu32_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  input  logic             req_mode,
  input  logic [3:0]       req_sel,
  input  logic             req_cin_n,
  input  logic             req_wide,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_result,
  output logic             resp_cout_n,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;

  logic [63:0] a_p0, b_p0;
  logic        mode_p0, cin_n_p0, wide_p0;
  logic [3:0]  sel_p0;
  logic [31:0] lo_res_p1, hi_res_p2;
  logic        lo_cout_n_p1, hi_cout_n_p2;

  logic [31:0] alu_a, alu_b, alu_f;
  logic        alu_cin_n, alu_cout_n;
  logic        accept;

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid)                state_nxt = ST_LO;
      ST_LO:                                 state_nxt = wide_p0 ? ST_HI : ST_DONE;
      ST_HI:                                 state_nxt = ST_DONE;
      ST_DONE: if (resp_valid && resp_ready) state_nxt = ST_IDLE;
      default:                               state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    alu_a     = a_p0[31:0];
    alu_b     = b_p0[31:0];
    alu_cin_n = cin_n_p0;
    if (state == ST_HI) begin
      alu_a     = a_p0[63:32];
      alu_b     = b_p0[63:32];
      alu_cin_n = lo_cout_n_p1;
    end
  end

  alu32 #(.DATA_W(32)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .mode   (mode_p0),
    .sel    (sel_p0),
    .cin_n  (alu_cin_n),
    .f      (alu_f),
    .cout_n (alu_cout_n)
  );

  // p0: request latch, p1: low-half pass, p2: high-half pass
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0     <= req_a;
      b_p0     <= req_b;
      mode_p0  <= req_mode;
      sel_p0   <= req_sel;
      cin_n_p0 <= req_cin_n;
      wide_p0  <= req_wide;
    end
    if (state == ST_LO) begin
      lo_res_p1    <= alu_f;
      lo_cout_n_p1 <= alu_cout_n;
    end
    if (state == ST_HI) begin
      hi_res_p2    <= alu_f;
      hi_cout_n_p2 <= alu_cout_n;
    end
  end

  // First DONE cycle assembles the response; it then holds until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_cout_n <= 1'b1;
      op_count    <= '0;
    end else if (state == ST_DONE) begin
      if (!resp_valid) begin
        resp_valid  <= 1'b1;
        resp_result <= wide_p0 ? {hi_res_p2, lo_res_p1} : {32'd0, lo_res_p1};
        resp_cout_n <= mode_p0 | (wide_p0 ? hi_cout_n_p2 : lo_cout_n_p1);
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
        if (op_count != CNT_MAX) op_count <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/alu32_seq_ctrl.md
ALU32_SEQ_CTRL -- requirements
Module: alu32_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of completed-operation counter.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  controller accepts request this cycle.
REQ-006 SHALL have ports req_a, req_b  input  64 each  operands.
REQ-007 SHALL have port req_mode  input  1  74181 M (0 arithmetic, 1 logic).
REQ-008 SHALL have port req_sel  input  4  74181 S3..S0.
REQ-009 SHALL have port req_cin_n  input  1  carry-in, active-low (74181 Cn).
REQ-010 SHALL have port req_wide  input  1  1 = 64-bit op (two passes), 0 = 32-bit op (one pass).
REQ-011 SHALL have port resp_valid  output  1  result available.
REQ-012 SHALL have port resp_ready  input  1  consumer takes result.
REQ-013 SHALL have port resp_result  output  64  operation result.
REQ-014 SHALL have port resp_cout_n  output  1  carry-out, active-low (74181 Cn+4).
REQ-015 SHALL have port busy  output  1  state not IDLE.
REQ-016 SHALL have port op_count  output  CNT_W  completed responses, saturating.

Function
REQ-017 SHALL sequence one alu32 instance (32-bit, active-high data, active-low carry) through FSM IDLE -> LO -> HI -> DONE -> IDLE.
REQ-018 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready, latching operands, mode, sel, cin_n, wide.
REQ-019 LO: ALU driven with a[31:0], b[31:0], latched cin_n; result and cout_n registered at end of cycle.
REQ-020 HI: ALU driven with a[63:32], b[63:32], Cin = registered LO cout_n (no inversion); result and cout_n registered.
REQ-021 req_wide=0 SHALL go LO -> DONE, resp_result[63:32] = 0, resp_cout_n = LO cout_n.
REQ-022 Latency: accept at edge N; resp_valid high from edge N+3 (wide) or N+2 (narrow).
REQ-023 In logic mode (mode=1) resp_cout_n SHALL be forced 1; carry not chained.
REQ-024 DONE SHALL hold resp_valid, resp_result, resp_cout_n stable until resp_ready=1, then IDLE next edge; no new accept in that same cycle.
REQ-025 op_count SHALL increment on each DONE&resp_ready handshake, saturating at 2^CNT_W-1.
REQ-026 req_* changes outside the accept cycle SHALL not affect an operation in flight.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE, req_ready=1 on release, resp_valid=0, resp_result=0, resp_cout_n=1, busy=0, op_count=0.
REQ-028 Reset in LO, HI or DONE SHALL abort the operation with no response and no op_count increment.

Structure
REQ-029 Shared package alu32_seq_pkg SHALL hold the FSM state enum and sel constants SEL_ADD=4'b1001, SEL_SUB=4'b0110, SEL_XOR=4'b0110 (with M=1).
REQ-030 SHALL instantiate exactly one alu32 as sub-module u_alu; controller contains no other arithmetic except op_count.

Verification
REQ-031 Wide add a=0x0000_0000_FFFF_FFFF, b=1, M=0, sel=1001, cin_n=1 -> result 0x0000_0001_0000_0000, cout_n=1, resp_valid at N+3.
REQ-032 Wide add a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin_n=1 -> result 0, cout_n=0.
REQ-033 Wide sub a=0x0000_0001_0000_0000, b=1, M=0, sel=0110, cin_n=0 -> result 0x0000_0000_FFFF_FFFF, cout_n=0.
REQ-034 Logic xor a=0xF0F0_F0F0_0F0F_0F0F, b=0xFFFF_0000_FFFF_0000, M=1, sel=0110 -> result 0x0F0F_F0F0_F0F0_0F0F, cout_n=1.
REQ-035 Narrow add a=0xFFFF_FFFF_FFFF_FFFF, b=1, wide=0 -> result 0, cout_n=0, resp_valid at N+2; resp_ready held 0 five cycles -> outputs stable, req_ready=0.
REQ-036 rst_n=0 during HI -> no resp_valid, op_count unchanged; op_count with CNT_W=2 after 5 handshakes reads 3.
